// File: rtl/quant_pkg.sv
// ---------------------------------------------------------------------------
// quant_pkg
//   Shared definitions for fixed-point requantizing blocks.
//   - round_mode_e : rounding selection carried with each beat
//                    (encoding 3 is unused and behaves as truncation).
//   - quant_shift  : number of fraction bits dropped (IN_FRAC - OUT_FRAC).
//   - quant_rnd_width : width of the rounded intermediate; one bit wider
//                    than the floor value so that rounding up can never
//                    overflow before the range check.
// ---------------------------------------------------------------------------
package quant_pkg;

    typedef enum logic [1:0] {
        ROUND_TRUNC     = 2'd0,
        ROUND_HALF_UP   = 2'd1,
        ROUND_HALF_EVEN = 2'd2
    } round_mode_e;

    function automatic int quant_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    function automatic int quant_rnd_width(input int in_w, input int shift);
        return in_w - shift + 1;
    endfunction

endpackage

// File: rtl/quant_lane.sv
// ---------------------------------------------------------------------------
// quant_lane
//   Combinational requantization of one signed lane, split in two halves so
//   the caller can place a register between them:
//     round half : in_word, round_mode -> rnd_word (RND_W bits, signed)
//     range half : rnd_in, sat_en      -> out_word, out_sat
//   Ports
//     in_word    IN_W-bit signed input sample
//     round_mode rounding selection (quant_pkg::round_mode_e encoding)
//     rnd_word   rounded value, input scaled down by SHIFT
//     rnd_in     rounded value coming back from the caller's register
//     sat_en     1 = clamp out-of-range values, 0 = keep the low OUT_W bits
//     out_word   OUT_W-bit signed result
//     out_sat    rounded value did not fit in OUT_W bits
// ---------------------------------------------------------------------------
module quant_lane
    import quant_pkg::*;
#(
    parameter  int IN_W     = 16,
    parameter  int IN_FRAC  = 14,
    parameter  int OUT_W    = 8,
    parameter  int OUT_FRAC = 7,
    localparam int SHIFT    = quant_shift(IN_FRAC, OUT_FRAC),
    localparam int RND_W    = quant_rnd_width(IN_W, SHIFT)
) (
    input  logic [IN_W-1:0]  in_word,
    input  logic [1:0]       round_mode,
    output logic [RND_W-1:0] rnd_word,
    input  logic [RND_W-1:0] rnd_in,
    input  logic             sat_en,
    output logic [OUT_W-1:0] out_word,
    output logic             out_sat
);

    if (SHIFT < 1) begin : g_bad_shift
        $error("quant_lane: IN_FRAC must exceed OUT_FRAC by at least one bit");
    end

    // ---------------- round half ----------------
    logic [RND_W-1:0] floor_v;   // in >>> SHIFT, sign-extended by one bit
    logic             guard_bit;
    logic             sticky_bit;
    logic             inc;

    assign floor_v   = {in_word[IN_W-1], in_word[IN_W-1:SHIFT]};
    assign guard_bit = in_word[SHIFT-1];

    if (SHIFT >= 2) begin : g_sticky
        assign sticky_bit = |in_word[SHIFT-2:0];
    end else begin : g_no_sticky
        assign sticky_bit = 1'b0;
    end

    always_comb begin
        inc = 1'b0;
        case (round_mode)
            ROUND_HALF_UP:   inc = guard_bit;
            // An exact tie (no sticky bits) only rounds up from an odd value.
            ROUND_HALF_EVEN: inc = guard_bit & (sticky_bit | floor_v[0]);
            default:         inc = 1'b0;
        endcase
        rnd_word = floor_v + {{(RND_W-1){1'b0}}, inc};
    end

    // ---------------- range half ----------------
    if (RND_W > OUT_W) begin : g_range
        localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
        localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

        // The value fits when every bit from the output sign bit upwards
        // is a copy of the sign.
        logic [RND_W-OUT_W:0] upper;
        logic                 in_range;

        assign upper    = rnd_in[RND_W-1:OUT_W-1];
        assign in_range = (&upper) | (~|upper);

        always_comb begin
            out_sat  = ~in_range;
            out_word = rnd_in[OUT_W-1:0];
            if (!in_range && sat_en) begin
                out_word = rnd_in[RND_W-1] ? OUT_MIN : OUT_MAX;
            end
        end
    end else begin : g_extend
        // Narrow rounded value always fits: plain sign extension.
        assign out_word = OUT_W'($signed(rnd_in));
        assign out_sat  = 1'b0;
    end

endmodule

// File: rtl/stream_quantizer.sv
// ---------------------------------------------------------------------------
// stream_quantizer
//   LANES-wide pipelined fixed-point requantizer with valid/ready handshake.
//   Stage 1 registers the rounded lanes, stage 2 registers the range-checked
//   result; both advance together whenever the output is empty or accepted.
//   Ports
//     clk, rst    clock (rising edge), asynchronous active-high reset
//     in_valid    input beat valid; in_ready high when the beat is taken
//     in_data     LANES packed IN_W-bit signed lanes
//     round_mode  rounding selection, travels with the beat
//     sat_en      clamp (1) or wrap (0), travels with the beat
//     out_valid   output beat valid; out_ready from downstream
//     out_data    LANES packed OUT_W-bit signed lanes
//     out_sat     per-lane out-of-range flag
//     sat_cnt     count of transferred beats with any out_sat bit, sticky
//     sat_clr     synchronous clear of sat_cnt (wins over an increment)
// ---------------------------------------------------------------------------
module stream_quantizer
    import quant_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = 14,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 7,
    parameter int LANES    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [1:0]             round_mode,
    input  logic                   sat_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    output logic [CNT_W-1:0]       sat_cnt,
    input  logic                   sat_clr
);

    localparam int SHIFT = quant_shift(IN_FRAC, OUT_FRAC);
    localparam int RND_W = quant_rnd_width(IN_W, SHIFT);

    logic                        adv;

    logic [LANES-1:0][RND_W-1:0] lane_rnd;
    logic [LANES-1:0][OUT_W-1:0] lane_out;
    logic [LANES-1:0]            lane_sat;

    logic                        s1_valid_d,  s1_valid_q;
    logic                        s1_sat_en_d, s1_sat_en_q;
    logic [LANES-1:0][RND_W-1:0] s1_rnd_d,    s1_rnd_q;

    logic                        out_valid_d, out_valid_q;
    logic [LANES-1:0][OUT_W-1:0] out_data_d,  out_data_q;
    logic [LANES-1:0]            out_sat_d,   out_sat_q;

    logic [CNT_W-1:0]            sat_cnt_d,   sat_cnt_q;

    // Round half is fed from the input port, range half from stage 1.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        quant_lane #(
            .IN_W     (IN_W),
            .IN_FRAC  (IN_FRAC),
            .OUT_W    (OUT_W),
            .OUT_FRAC (OUT_FRAC)
        ) u_lane (
            .in_word    (in_data[gi*IN_W +: IN_W]),
            .round_mode (round_mode),
            .rnd_word   (lane_rnd[gi]),
            .rnd_in     (s1_rnd_q[gi]),
            .sat_en     (s1_sat_en_q),
            .out_word   (lane_out[gi]),
            .out_sat    (lane_sat[gi])
        );
    end

    always_comb begin
        adv         = !out_valid_q || out_ready;

        s1_valid_d  = s1_valid_q;
        s1_sat_en_d = s1_sat_en_q;
        s1_rnd_d    = s1_rnd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        sat_cnt_d   = sat_cnt_q;

        if (adv) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            // Payload only moves with a valid beat so bubbles do not toggle it.
            if (in_valid) begin
                s1_sat_en_d = sat_en;
                s1_rnd_d    = lane_rnd;
            end
            if (s1_valid_q) begin
                out_data_d = lane_out;
                out_sat_d  = lane_sat;
            end
        end

        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready && (|out_sat_q) && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sat_en_q <= 1'b0;
            s1_rnd_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sat_en_q <= s1_sat_en_d;
            s1_rnd_q    <= s1_rnd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule
